// File: rtl/rom_read_arbiter.sv
// rom_read_arbiter: shares one synchronous-read ROM port between NUM_REQ
// requesters using round-robin arbitration with a bounded burst length.
// Optional per-requester statistics counters are enabled with ARB_STATS_EN.
module rom_read_arbiter #(
    parameter int unsigned NUM_REQ   = 2,
    parameter int unsigned AWIDTH    = 10,
    parameter int unsigned DWIDTH    = 32,
    parameter int unsigned MAX_BURST = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*AWIDTH-1:0] req_addr,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [NUM_REQ-1:0]        resp_valid,
    output logic [DWIDTH-1:0]         resp_data,
    output logic                      rom_en,
    output logic [AWIDTH-1:0]         rom_addr,
    input  logic [DWIDTH-1:0]         rom_q
`ifdef ARB_STATS_EN
    ,
    output logic [NUM_REQ*32-1:0]     grant_cnt,
    output logic [31:0]               conflict_cnt
`endif
);

    localparam int unsigned IW = $clog2(NUM_REQ);
    localparam int unsigned BW = $clog2(MAX_BURST + 1);

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_e;

    state_e               state_q, state_d;
    logic [IW-1:0]        rr_ptr_q, rr_ptr_d;
    logic [IW-1:0]        owner_q, owner_d;
    logic [BW-1:0]        burst_cnt_q, burst_cnt_d;
    logic [NUM_REQ-1:0]   resp_valid_q, resp_valid_d;

    logic [NUM_REQ-1:0]   grant;
    logic [NUM_REQ-1:0]   owner_mask;
    logic                 others_valid;
    logic [IW-1:0]        next_owner;
    logic [IW:0]          hit;

    // First valid, unmasked requester at or after start (modulo NUM_REQ); MSB = found.
    function automatic logic [IW:0] rr_search(input logic [NUM_REQ-1:0] vld,
                                              input logic [IW-1:0]      start,
                                              input logic [NUM_REQ-1:0] mask);
        logic [IW:0] res;
        int unsigned idx;
        res = '0;
        for (int unsigned o = 0; o < NUM_REQ; o++) begin
            idx = (32'(start) + o) % NUM_REQ;
            if (!res[IW] && vld[IW'(idx)] && !mask[IW'(idx)]) begin
                res = {1'b1, IW'(idx)};
            end
        end
        return res;
    endfunction

    // Arbitration: next state, burst tracking and the grant vector.
    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        owner_d      = owner_q;
        burst_cnt_d  = burst_cnt_q;
        grant        = '0;
        hit          = '0;
        owner_mask   = '0;
        owner_mask[owner_q] = 1'b1;
        others_valid = |(req_valid & ~owner_mask);
        next_owner   = IW'((32'(owner_q) + 32'd1) % NUM_REQ);

        case (state_q)
            IDLE: begin
                hit = rr_search(req_valid, rr_ptr_q, '0);
                if (hit[IW]) begin
                    grant[hit[IW-1:0]] = 1'b1;
                    owner_d            = hit[IW-1:0];
                    burst_cnt_d        = BW'(1);
                    state_d            = BURST;
                end
            end
            BURST: begin
                if (req_valid[owner_q] &&
                    ((burst_cnt_q < BW'(MAX_BURST)) || !others_valid)) begin
                    grant[owner_q] = 1'b1;
                    if (burst_cnt_q < BW'(MAX_BURST)) begin
                        burst_cnt_d = burst_cnt_q + BW'(1);
                    end
                end else begin
                    hit = rr_search(req_valid, next_owner, owner_mask);
                    if (hit[IW]) begin
                        grant[hit[IW-1:0]] = 1'b1;
                        owner_d            = hit[IW-1:0];
                        burst_cnt_d        = BW'(1);
                    end else begin
                        state_d  = IDLE;
                        rr_ptr_d = next_owner;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // No handshake may complete while reset is held.
        if (!rst_n) begin
            grant = '0;
        end
        resp_valid_d = grant;
    end

    // ROM port drive: address of the granted requester, zero when idle.
    always_comb begin
        rom_addr = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (grant[i]) begin
                rom_addr = req_addr[i*AWIDTH +: AWIDTH];
            end
        end
    end

    assign req_ready  = grant;
    assign rom_en     = |grant;
    assign resp_valid = resp_valid_q;
    assign resp_data  = rom_q;

    // Arbiter state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            rr_ptr_q     <= '0;
            owner_q      <= '0;
            burst_cnt_q  <= '0;
            resp_valid_q <= '0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            owner_q      <= owner_d;
            burst_cnt_q  <= burst_cnt_d;
            resp_valid_q <= resp_valid_d;
        end
    end

`ifdef ARB_STATS_EN
    logic [NUM_REQ*32-1:0] grant_cnt_q, grant_cnt_d;
    logic [31:0]           conflict_cnt_q, conflict_cnt_d;

    // Saturating grant and contention counters.
    always_comb begin
        grant_cnt_d    = grant_cnt_q;
        conflict_cnt_d = conflict_cnt_q;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (grant[i] && (grant_cnt_q[i*32 +: 32] != 32'hFFFF_FFFF)) begin
                grant_cnt_d[i*32 +: 32] = grant_cnt_q[i*32 +: 32] + 32'd1;
            end
        end
        if (($countones(req_valid) > 1) && (conflict_cnt_q != 32'hFFFF_FFFF)) begin
            conflict_cnt_d = conflict_cnt_q + 32'd1;
        end
    end

    // Statistics registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_cnt_q    <= '0;
            conflict_cnt_q <= '0;
        end else begin
            grant_cnt_q    <= grant_cnt_d;
            conflict_cnt_q <= conflict_cnt_d;
        end
    end

    assign grant_cnt    = grant_cnt_q;
    assign conflict_cnt = conflict_cnt_q;
`endif

endmodule

// File: tb/tb_rom_read_arbiter.sv
// Testbench for rom_read_arbiter: scoreboard-checked responses plus
// per-scenario grant sequence checks. Covers ARB_STATS_EN when defined.
module tb_rom_read_arbiter;

    localparam int unsigned NUM_REQ   = 2;
    localparam int unsigned AWIDTH    = 10;
    localparam int unsigned DWIDTH    = 32;
    localparam int unsigned MAX_BURST = 8;

    typedef struct {
        int          req;
        logic [31:0] data;
    } exp_t;

    logic                      clk;
    logic                      rst_n;
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*AWIDTH-1:0] req_addr;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ-1:0]        resp_valid;
    logic [DWIDTH-1:0]         resp_data;
    logic                      rom_en;
    logic [AWIDTH-1:0]         rom_addr;
    logic [DWIDTH-1:0]         rom_q;
`ifdef ARB_STATS_EN
    logic [NUM_REQ*32-1:0]     grant_cnt;
    logic [31:0]               conflict_cnt;
`endif

    logic [AWIDTH-1:0] addr [NUM_REQ];
    logic [DWIDTH-1:0] rom  [1024];
    exp_t              sb   [$];
    int                n_chk;
    int                n_fail;
    longint            sum0;
    int                cnt0;

    rom_read_arbiter #(
        .NUM_REQ  (NUM_REQ),
        .AWIDTH   (AWIDTH),
        .DWIDTH   (DWIDTH),
        .MAX_BURST(MAX_BURST)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_ready (req_ready),
        .resp_valid(resp_valid),
        .resp_data (resp_data),
        .rom_en    (rom_en),
        .rom_addr  (rom_addr),
        .rom_q     (rom_q)
`ifdef ARB_STATS_EN
        ,
        .grant_cnt   (grant_cnt),
        .conflict_cnt(conflict_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb req_addr = {addr[1], addr[0]};

    // Behavioural ROM: one-cycle registered read.
    always @(posedge clk) begin
        if (rom_en) rom_q <= rom[rom_addr];
    end

    // Scoreboard: compare responses, then record this cycle's transfer.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            sb.delete();
            n_chk++;
            if (resp_valid !== '0 || req_ready !== '0 || rom_en !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_outputs: resp_valid=%b req_ready=%b rom_en=%b, required all 0",
                         resp_valid, req_ready, rom_en);
            end
        end else begin
            n_chk++;
            if (sb.size() != 0) begin
                e = sb.pop_front();
                if (resp_valid !== (2'b01 << e.req) || resp_data !== e.data) begin
                    n_fail++;
                    $display("FAIL response: resp_valid=%b resp_data=%0d, required %b / %0d",
                             resp_valid, resp_data, 2'b01 << e.req, e.data);
                end
            end else if (resp_valid !== '0) begin
                n_fail++;
                $display("FAIL spurious_response: resp_valid=%b, required 00", resp_valid);
            end
            if (resp_valid[0] === 1'b1) begin
                sum0 += longint'(resp_data);
                cnt0++;
            end
            n_chk++;
            if ($countones(req_ready) > 1 || (req_ready & ~req_valid) != '0 ||
                rom_en !== (|req_ready)) begin
                n_fail++;
                $display("FAIL grant_shape: req_ready=%b req_valid=%b rom_en=%b, required one-hot subset with rom_en=|ready",
                         req_ready, req_valid, rom_en);
            end
            if (req_ready == '0) begin
                n_chk++;
                if (rom_addr !== '0) begin
                    n_fail++;
                    $display("FAIL idle_rom_addr: rom_addr=%0d, required 0", rom_addr);
                end
            end
            for (int i = 0; i < int'(NUM_REQ); i++) begin
                if (req_ready[i] === 1'b1) begin
                    n_chk++;
                    if (rom_addr !== addr[i]) begin
                        n_fail++;
                        $display("FAIL rom_addr: req=%0d rom_addr=%0d, required %0d", i, rom_addr, addr[i]);
                    end
                    sb.push_back('{req: i, data: rom[addr[i]]});
                end
            end
        end
    end

    // One clock of stimulus: report accepted requesters, advance their addresses.
    task automatic step(output logic [NUM_REQ-1:0] acc);
        @(negedge clk);
        acc = req_ready & req_valid;
        @(posedge clk);
        #1;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (acc[i]) addr[i] = addr[i] + AWIDTH'(1);
        end
    endtask

    task automatic test_reset();
        logic [NUM_REQ-1:0] acc;
        rst_n     = 1'b0;
        req_valid = 2'b11;
        step(acc);
        step(acc);
        n_chk++;
        if (resp_valid !== '0 || acc !== '0 || rom_en !== 1'b0 || rom_addr !== '0) begin
            n_fail++;
            $display("FAIL test_reset: resp_valid=%b ready=%b rom_en=%b rom_addr=%0d, required 0",
                     resp_valid, acc, rom_en, rom_addr);
        end
        req_valid = '0;
        rst_n     = 1'b1;
        step(acc);
    endtask

    task automatic test_single();
        logic [NUM_REQ-1:0] acc;
        sum0      = 0;
        cnt0      = 0;
        addr[0]   = '0;
        req_valid = 2'b01;
        for (int n = 0; n < 1024; n++) begin
            step(acc);
            n_chk++;
            if (acc !== 2'b01) begin
                n_fail++;
                $display("FAIL single_ready: cycle=%0d accepted=%b, required 01", n, acc);
            end
        end
        req_valid = '0;
        step(acc);
        n_chk++;
        if (acc !== '0) begin
            n_fail++;
            $display("FAIL single_drop: accepted=%b, required 00", acc);
        end
        n_chk++;
        if (sum0 != 64'd523776 || cnt0 != 1024) begin
            n_fail++;
            $display("FAIL single_sum: sum=%0d count=%0d, required 523776 / 1024", sum0, cnt0);
        end
    endtask

    task automatic test_alternate();
        logic [NUM_REQ-1:0] acc;
        int                 exp_owner;
        int                 run;
        addr[0]   = 10'd100;
        addr[1]   = 10'd700;
        exp_owner = 1;
        run       = 0;
        req_valid = 2'b11;
        for (int n = 0; n < 48; n++) begin
            step(acc);
            n_chk++;
            if (acc !== (2'b01 << exp_owner)) begin
                n_fail++;
                $display("FAIL alternate: cycle=%0d accepted=%b, required %b", n, acc, 2'b01 << exp_owner);
            end
            run++;
            if (run == int'(MAX_BURST)) begin
                run       = 0;
                exp_owner = 1 - exp_owner;
            end
        end
        req_valid = '0;
        step(acc);
        n_chk++;
        if (acc !== '0) begin
            n_fail++;
            $display("FAIL alternate_drop: accepted=%b, required 00", acc);
        end
    endtask

    task automatic test_burst_cut();
        logic [NUM_REQ-1:0] acc;
        logic [NUM_REQ-1:0] vld_tab [7] = '{2'b01, 2'b11, 2'b11, 2'b10, 2'b10, 2'b10, 2'b00};
        logic [NUM_REQ-1:0] exp_tab [7] = '{2'b01, 2'b01, 2'b01, 2'b10, 2'b10, 2'b10, 2'b00};
        addr[0] = 10'd40;
        addr[1] = 10'd900;
        for (int n = 0; n < 7; n++) begin
            req_valid = vld_tab[n];
            step(acc);
            n_chk++;
            if (acc !== exp_tab[n]) begin
                n_fail++;
                $display("FAIL burst_cut: cycle=%0d accepted=%b, required %b", n, acc, exp_tab[n]);
            end
        end
    endtask

    task automatic test_idle_rotation();
        logic [NUM_REQ-1:0] acc;
        logic [NUM_REQ-1:0] vld_tab [3] = '{2'b11, 2'b11, 2'b00};
        logic [NUM_REQ-1:0] exp_tab [3] = '{2'b01, 2'b01, 2'b00};
        for (int n = 0; n < 3; n++) begin
            req_valid = vld_tab[n];
            step(acc);
            n_chk++;
            if (acc !== exp_tab[n]) begin
                n_fail++;
                $display("FAIL idle_rotation: cycle=%0d accepted=%b, required %b", n, acc, exp_tab[n]);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [NUM_REQ-1:0] acc;
        addr[0]   = 10'd321;
        addr[1]   = 10'd654;
        req_valid = 2'b01;
        step(acc);
        n_chk++;
        if (acc !== 2'b01) begin
            n_fail++;
            $display("FAIL reset_mid_xfer: accepted=%b, required 01", acc);
        end
        rst_n     = 1'b0;
        req_valid = 2'b11;
        #1;
        n_chk++;
        if (resp_valid !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_drop: resp_valid=%b, required 00", resp_valid);
        end
        @(negedge clk);
        n_chk++;
        if (rom_en !== 1'b0 || req_ready !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_gate: rom_en=%b req_ready=%b, required 0 / 00", rom_en, req_ready);
        end
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        req_valid = 2'b10;
        step(acc);
        n_chk++;
        if (acc !== 2'b10) begin
            n_fail++;
            $display("FAIL reset_mid_restart: accepted=%b, required 10", acc);
        end
        req_valid = '0;
        step(acc);
        step(acc);
    endtask

`ifdef ARB_STATS_EN
    task automatic test_stats();
        logic [NUM_REQ-1:0] acc;
        rst_n     = 1'b0;
        req_valid = '0;
        step(acc);
        rst_n     = 1'b1;
        req_valid = 2'b11;
        for (int n = 0; n < 64; n++) step(acc);
        req_valid = '0;
        step(acc);
        n_chk++;
        if (grant_cnt[31:0] !== 32'd32 || grant_cnt[63:32] !== 32'd32 || conflict_cnt !== 32'd64) begin
            n_fail++;
            $display("FAIL stats: grant0=%0d grant1=%0d conflict=%0d, required 32 / 32 / 64",
                     grant_cnt[31:0], grant_cnt[63:32], conflict_cnt);
        end
    endtask
`endif

    initial begin
        n_chk     = 0;
        n_fail    = 0;
        sum0      = 0;
        cnt0      = 0;
        rst_n     = 1'b0;
        req_valid = '0;
        addr[0]   = '0;
        addr[1]   = '0;
        for (int n = 0; n < 1024; n++) rom[n] = 32'(n);
        test_reset();
        test_single();
        test_alternate();
        test_burst_cut();
        test_idle_rotation();
        test_reset_mid();
`ifdef ARB_STATS_EN
        test_stats();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
